// File: rtl/codec_responder.sv
// I2S slave codec: deserialises playback words, serialises record words; BCLK is sampled, never a clock.
// Playback word visible one CLK after its last bit's rise; no backpressure, record words are latched on word-select change.
module codec_responder #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BCLK,
  input  logic             PBLRC,
  input  logic             PBDAT,
  input  logic             RECLRC,
  output logic             RECDAT,
  output logic [WIDTH-1:0] PB_LEFT,
  output logic [WIDTH-1:0] PB_RIGHT,
  output logic             PB_VALID_LEFT,
  output logic             PB_VALID_RIGHT,
  input  logic [WIDTH-1:0] REC_LEFT,
  input  logic [WIDTH-1:0] REC_RIGHT,
  output logic             REC_TAKEN_LEFT,
  output logic             REC_TAKEN_RIGHT,
  output logic             FRAME_ERR
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DELAY, RX_SHIFT, RX_DONE} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_ARMED, TX_SHIFT, TX_DONE} tx_state_t;

  logic bclk_q, bclk_q2, pblrc_q, reclrc_q, pbdat_q;
  logic rise, fall;
  logic ref_vld, pb_ref, rec_ref;
  logic pb_change, rec_change;
  logic rx_err, tx_err;

  rx_state_t        rx_state;
  logic             rx_chan;
  logic [CW-1:0]    rx_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic             rx_commit;

  tx_state_t        tx_state;
  logic [CW-1:0]    tx_cnt;
  logic [WIDTH-1:0] tx_shift;

  assign rise = bclk_q & ~bclk_q2;
  assign fall = ~bclk_q & bclk_q2;

  // The first rise after reset only establishes the word-select references.
  assign pb_change  = rise & ref_vld & (pblrc_q != pb_ref);
  assign rec_change = rise & ref_vld & (reclrc_q != rec_ref);

  assign rx_err = pb_change & ((rx_state == RX_DELAY) || (rx_state == RX_SHIFT));
  assign tx_err = rec_change & ((tx_state == TX_ARMED) ||
                                ((tx_state == TX_SHIFT) && (tx_cnt != CW'(WIDTH))));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bclk_q   <= 1'b0;
      bclk_q2  <= 1'b0;
      pblrc_q  <= 1'b0;
      reclrc_q <= 1'b0;
      pbdat_q  <= 1'b0;
      ref_vld  <= 1'b0;
      pb_ref   <= 1'b0;
      rec_ref  <= 1'b0;
    end else begin
      bclk_q   <= BCLK;
      bclk_q2  <= bclk_q;
      pblrc_q  <= PBLRC;
      reclrc_q <= RECLRC;
      pbdat_q  <= PBDAT;
      if (rise) begin
        ref_vld <= 1'b1;
        pb_ref  <= pblrc_q;
        rec_ref <= reclrc_q;
      end
    end
  end

  // The rise that reveals a word-select change carries the previous word's LSB
  // (the I2S delay slot), so data is shifted from the rise after it onwards.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_state       <= RX_IDLE;
      rx_chan        <= 1'b0;
      rx_cnt         <= '0;
      rx_shift       <= '0;
      rx_commit      <= 1'b0;
      PB_LEFT        <= '0;
      PB_RIGHT       <= '0;
      PB_VALID_LEFT  <= 1'b0;
      PB_VALID_RIGHT <= 1'b0;
    end else begin
      PB_VALID_LEFT  <= 1'b0;
      PB_VALID_RIGHT <= 1'b0;
      rx_commit      <= 1'b0;
      if (rx_commit) begin
        if (rx_chan) begin
          PB_RIGHT       <= rx_shift;
          PB_VALID_RIGHT <= 1'b1;
        end else begin
          PB_LEFT        <= rx_shift;
          PB_VALID_LEFT  <= 1'b1;
        end
      end
      if (pb_change) begin
        rx_state <= RX_DELAY;
        rx_chan  <= pblrc_q;
        rx_cnt   <= '0;
      end else if (rise) begin
        case (rx_state)
          RX_DELAY, RX_SHIFT: begin
            rx_shift <= {rx_shift[WIDTH-2:0], pbdat_q};
            rx_cnt   <= rx_cnt + CW'(1);
            if (rx_cnt == CW'(WIDTH - 1)) begin
              rx_state  <= RX_DONE;
              rx_commit <= 1'b1;
            end else begin
              rx_state <= RX_SHIFT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // tx_cnt counts bits already driven; at WIDTH the LSB is on the wire.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_state        <= TX_IDLE;
      tx_cnt          <= '0;
      tx_shift        <= '0;
      RECDAT          <= 1'b0;
      REC_TAKEN_LEFT  <= 1'b0;
      REC_TAKEN_RIGHT <= 1'b0;
    end else begin
      REC_TAKEN_LEFT  <= 1'b0;
      REC_TAKEN_RIGHT <= 1'b0;
      if (rec_change) begin
        tx_shift        <= reclrc_q ? REC_RIGHT : REC_LEFT;
        REC_TAKEN_LEFT  <= ~reclrc_q;
        REC_TAKEN_RIGHT <= reclrc_q;
        tx_state        <= TX_ARMED;
        tx_cnt          <= '0;
      end else if (fall) begin
        case (tx_state)
          TX_ARMED, TX_SHIFT: begin
            if (tx_cnt == CW'(WIDTH)) begin
              RECDAT   <= 1'b0;
              tx_state <= TX_DONE;
            end else begin
              RECDAT   <= tx_shift[WIDTH-1];
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
              tx_cnt   <= tx_cnt + CW'(1);
              tx_state <= TX_SHIFT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= rx_err | tx_err;
    end
  end

endmodule

// File: tb/tb_codec_responder.sv
// Randomised I2S master + scoreboard bench for codec_responder (playback, record, errors, stall, reset, loopback).
module tb_codec_responder;
  localparam int W = 16;
  localparam int M_NORM = 0, M_CUT = 1, M_STALL = 2, M_RESET = 3, M_LOOP = 4;

  logic CLK = 1'b0;
  logic RESET, BCLK, PBLRC, PBDAT, RECLRC, RECDAT;
  logic [W-1:0] PB_LEFT, PB_RIGHT, REC_LEFT, REC_RIGHT;
  logic PB_VALID_LEFT, PB_VALID_RIGHT, REC_TAKEN_LEFT, REC_TAKEN_RIGHT, FRAME_ERR;
  logic pbdat_drv, loopback;

  assign PBDAT = loopback ? RECDAT : pbdat_drv;

  codec_responder #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .BCLK(BCLK), .PBLRC(PBLRC), .PBDAT(PBDAT),
    .RECLRC(RECLRC), .RECDAT(RECDAT), .PB_LEFT(PB_LEFT), .PB_RIGHT(PB_RIGHT),
    .PB_VALID_LEFT(PB_VALID_LEFT), .PB_VALID_RIGHT(PB_VALID_RIGHT),
    .REC_LEFT(REC_LEFT), .REC_RIGHT(REC_RIGHT),
    .REC_TAKEN_LEFT(REC_TAKEN_LEFT), .REC_TAKEN_RIGHT(REC_TAKEN_RIGHT),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {bit ch; logic [W-1:0] w;} pb_exp_t;
  pb_exp_t pb_q[$];
  logic [W-1:0] rec_q[$];

  int vectors = 0, miscompares = 0;
  int err_cnt = 0, exp_err = 0;
  int taken_l = 0, taken_r = 0, exp_taken_l = 0, exp_taken_r = 0;
  int valid_l = 0, valid_r = 0;
  logic [W-1:0] last_l = '0, last_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the playback scoreboard whenever the DUT presents a word.
  always @(negedge CLK) begin
    pb_exp_t e;
    if (PB_VALID_LEFT) begin
      valid_l++;
      check("pb_left_expected", 32'(pb_q.size() > 0), 1);
      if (pb_q.size() > 0) begin
        e = pb_q.pop_front();
        check("pb_left_chan", 0, 32'(e.ch));
        check("pb_left_word", PB_LEFT, e.w);
      end
    end
    if (PB_VALID_RIGHT) begin
      valid_r++;
      check("pb_right_expected", 32'(pb_q.size() > 0), 1);
      if (pb_q.size() > 0) begin
        e = pb_q.pop_front();
        check("pb_right_chan", 1, 32'(e.ch));
        check("pb_right_word", PB_RIGHT, e.w);
      end
    end
    if (REC_TAKEN_LEFT)  taken_l++;
    if (REC_TAKEN_RIGHT) taken_r++;
    if (FRAME_ERR)       err_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic half();
    repeat (4) @(posedge CLK);
    #1;
  endtask

  // One channel of a 32-slot I2S frame; slot 0 is the delay slot, slots 1..W carry the word MSB first.
  task automatic send_channel(input bit ch, input logic [W-1:0] pbw, input logic [W-1:0] recw, input int mode);
    logic [W-1:0] got, pb_word;
    pb_exp_t e;
    bit tail_bad;
    int last, act0;
    got = '0;
    tail_bad = 0;
    last = (mode == M_CUT) ? 9 : 31;
    pb_word = (mode == M_LOOP) ? recw : pbw;
    if (ch) REC_RIGHT = recw; else REC_LEFT = recw;
    if (mode != M_CUT && mode != M_RESET) begin
      e.ch = ch;
      e.w = pb_word;
      pb_q.push_back(e);
      rec_q.push_back(recw);
    end
    if (ch) exp_taken_r++; else exp_taken_l++;
    for (int s = 0; s <= last; s++) begin
      BCLK = 1'b0;
      PBLRC = ch;
      RECLRC = ch;
      pbdat_drv = (s >= 1 && s <= W) ? pbw[W-s] : 1'($urandom);
      half();
      BCLK = 1'b1;
      if (s >= 1 && s <= W) got[W-s] = RECDAT;
      else if (s > W && RECDAT !== 1'b0) tail_bad = 1;
      half();
      if (mode == M_STALL && s == 8) begin
        act0 = valid_l + valid_r + taken_l + taken_r + err_cnt;
        repeat (200) @(posedge CLK);
        #1;
        check("stall_pb_left", PB_LEFT, last_l);
        check("stall_pb_right", PB_RIGHT, last_r);
        check("stall_recdat", RECDAT, recw[W-8]);
        check("stall_activity", valid_l + valid_r + taken_l + taken_r + err_cnt, act0);
      end
      if (mode == M_RESET && s == 7) begin
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_mid_pb_left", PB_LEFT, 0);
        check("rst_mid_pb_right", PB_RIGHT, 0);
        check("rst_mid_bits", {RECDAT, PB_VALID_LEFT, PB_VALID_RIGHT, REC_TAKEN_LEFT, REC_TAKEN_RIGHT, FRAME_ERR}, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        last_l = '0;
        last_r = '0;
      end
    end
    if (mode != M_CUT && mode != M_RESET) begin
      check("rec_word", got, rec_q.pop_front());
      check("rec_tail_zero", 32'(tail_bad), 0);
      if (ch) last_r = pb_word; else last_l = pb_word;
    end
    check("taken_left_count", taken_l, exp_taken_l);
    check("taken_right_count", taken_r, exp_taken_r);
  endtask

  task automatic send_frame(input logic [W-1:0] pl, input logic [W-1:0] pr,
                            input logic [W-1:0] rl, input logic [W-1:0] rr, input int mode);
    send_channel(1'b0, pl, rl, mode);
    send_channel(1'b1, pr, rr, mode);
  endtask

  initial begin
    RESET = 1'b1;
    BCLK = 1'b0;
    PBLRC = 1'b0;
    RECLRC = 1'b0;
    pbdat_drv = 1'b0;
    loopback = 1'b0;
    REC_LEFT = '0;
    REC_RIGHT = '0;
    repeat (5) @(posedge CLK);
    #1;
    check("reset_pb_left", PB_LEFT, 0);
    check("reset_pb_right", PB_RIGHT, 0);
    check("reset_recdat", RECDAT, 0);
    check("reset_pulses", {PB_VALID_LEFT, PB_VALID_RIGHT, REC_TAKEN_LEFT, REC_TAKEN_RIGHT, FRAME_ERR}, 0);
    RESET = 1'b0;

    // Preamble on the right channel so the first left slot is a genuine word-select change.
    for (int s = 0; s < 4; s++) begin
      BCLK = 1'b0; PBLRC = 1'b1; RECLRC = 1'b1; pbdat_drv = 1'b0;
      half();
      BCLK = 1'b1;
      half();
    end
    check("preamble_no_activity", valid_l + valid_r + taken_l + taken_r + err_cnt, 0);

    send_frame(16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, M_NORM);
    send_frame(16'hA5C3, 16'h1234, 16'h8001, 16'h7FFE, M_NORM);
    check("directed_pb_left", PB_LEFT, 16'hA5C3);
    check("directed_pb_right", PB_RIGHT, 16'h1234);
    check("directed_valid_left", valid_l, 2);
    check("directed_valid_right", valid_r, 2);

    for (int f = 0; f < 6; f++)
      send_frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom), M_NORM);
    check("random_frame_err", err_cnt, exp_err);

    send_channel(1'b0, W'($urandom), W'($urandom), M_CUT);
    exp_err++;
    send_channel(1'b1, 16'h00FF, W'($urandom), M_NORM);
    check("cut_frame_err", err_cnt, exp_err);
    check("cut_pb_right", PB_RIGHT, 16'h00FF);

    send_channel(1'b0, W'($urandom), W'($urandom), M_STALL);
    send_channel(1'b1, W'($urandom), W'($urandom), M_NORM);

    send_channel(1'b0, W'($urandom), W'($urandom), M_NORM);
    send_channel(1'b1, W'($urandom), W'($urandom), M_RESET);
    check("post_reset_pb_left", PB_LEFT, 0);
    check("post_reset_pb_right", PB_RIGHT, 0);
    send_frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom), M_NORM);
    check("post_reset_frame_err", err_cnt, exp_err);

    loopback = 1'b1;
    for (int f = 0; f < 100; f++)
      send_frame(W'($urandom), W'($urandom), W'($urandom), W'($urandom), M_LOOP);
    check("loop_frame_err", err_cnt, exp_err);

    repeat (20) @(posedge CLK);
    #1;
    check("pb_queue_drained", pb_q.size(), 0);
    check("rec_queue_drained", rec_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
